// File: rtl/vga_sync_gen.sv
// Raster timing generator: hpos/vpos counters with sync, display and line/frame strobes. Optional frame_cnt behind VGA_FRAME_COUNTER_EN.
// Latency: every output is a flop whose value is decoded from the next counter state, so sync/display_on always match hpos/vpos.
// Backpressure: ena=0 freezes counters and levels and forces both strobes low.
module vga_sync_gen #(
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
`ifdef VGA_FRAME_COUNTER_EN
    output logic       frame_start,
    output logic [7:0] frame_cnt
`else
    output logic       frame_start
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       hs_act;
    logic       vs_act;
    logic       de_nxt;
    logic       frame_nxt;

    always_comb begin
        h_wrap = (hpos == H_LAST);
        v_wrap = (vpos == V_LAST);
        h_nxt  = h_wrap ? 10'd0 : hpos + 10'd1;
        v_nxt  = vpos;
        if (h_wrap) begin
            v_nxt = v_wrap ? 10'd0 : vpos + 10'd1;
        end
        // Decode from the next state so the flopped levels line up with the flopped counters.
        hs_act    = (h_nxt >= HS_START) && (h_nxt < HS_END);
        vs_act    = (v_nxt >= VS_START) && (v_nxt < VS_END);
        de_nxt    = (h_nxt < H_VIS) && (v_nxt < V_VIS);
        frame_nxt = h_wrap && (v_nxt == 10'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            display_on  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ena) begin
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            hsync       <= hs_act ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= vs_act ? VSYNC_POL : ~VSYNC_POL;
            display_on  <= de_nxt;
            line_start  <= h_wrap;
            frame_start <= frame_nxt;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    // Starts at 255 so the first frame after reset reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 8'hFF;
        end else if (ena && frame_nxt) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: standard 640x480 instance plus a 14x7 small-parameter instance, closed-form raster model.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    logic       b_hs, b_vs, b_de, b_ls, b_fs;
    logic [9:0] b_h, b_v;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [9:0] s_h, s_v;
`ifdef VGA_FRAME_COUNTER_EN
    logic [7:0] b_fc, s_fc;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    vga_sync_gen u_big (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .hsync(b_hs), .vsync(b_vs), .display_on(b_de),
        .hpos(b_h), .vpos(b_v), .line_start(b_ls),
`ifdef VGA_FRAME_COUNTER_EN
        .frame_start(b_fs), .frame_cnt(b_fc)
`else
        .frame_start(b_fs)
`endif
    );

    vga_sync_gen #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .hsync(s_hs), .vsync(s_vs), .display_on(s_de),
        .hpos(s_h), .vpos(s_v), .line_start(s_ls),
`ifdef VGA_FRAME_COUNTER_EN
        .frame_start(s_fs), .frame_cnt(s_fc)
`else
        .frame_start(s_fs)
`endif
    );

    typedef struct {
        int h; int v; int hs; int vs; int de; int ls; int fs; int fc;
    } exp_t;

    // Raster position is simply (advances - 1) mod frame size; reset sits on the last pixel.
    function automatic exp_t model(input int n, input bit adv,
                                   input int hd, input int hf, input int hsw, input int hb,
                                   input int vd, input int vf, input int vsw, input int vb,
                                   input bit hp, input bit vp);
        exp_t e;
        int ht, vt, tot, pos;
        ht  = hd + hf + hsw + hb;
        vt  = vd + vf + vsw + vb;
        tot = ht * vt;
        pos = (n + tot - 1) % tot;
        e.h  = pos % ht;
        e.v  = pos / ht;
        e.hs = (e.h >= hd + hf && e.h < hd + hf + hsw) ? int'(hp) : int'(!hp);
        e.vs = (e.v >= vd + vf && e.v < vd + vf + vsw) ? int'(vp) : int'(!vp);
        e.de = (e.h < hd && e.v < vd) ? 1 : 0;
        e.ls = (adv && e.h == 0) ? 1 : 0;
        e.fs = (e.ls == 1 && e.v == 0) ? 1 : 0;
        e.fc = ((n + tot - 1) / tot + 255) % 256;
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    int n_adv;
    bit adv_last;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_adv    <= 0;
            adv_last <= 1'b0;
        end else if (ena) begin
            n_adv    <= n_adv + 1;
            adv_last <= 1'b1;
        end else begin
            adv_last <= 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t eb, es;
        eb = model(n_adv, adv_last, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        es = model(n_adv, adv_last, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b0);
        chk("big.hpos", int'(b_h), eb.h);
        chk("big.vpos", int'(b_v), eb.v);
        chk("big.hsync", int'(b_hs), eb.hs);
        chk("big.vsync", int'(b_vs), eb.vs);
        chk("big.display_on", int'(b_de), eb.de);
        chk("big.line_start", int'(b_ls), eb.ls);
        chk("big.frame_start", int'(b_fs), eb.fs);
        chk("sm.hpos", int'(s_h), es.h);
        chk("sm.vpos", int'(s_v), es.v);
        chk("sm.hsync", int'(s_hs), es.hs);
        chk("sm.vsync", int'(s_vs), es.vs);
        chk("sm.display_on", int'(s_de), es.de);
        chk("sm.line_start", int'(s_ls), es.ls);
        chk("sm.frame_start", int'(s_fs), es.fs);
`ifdef VGA_FRAME_COUNTER_EN
        chk("big.frame_cnt", int'(b_fc), eb.fc);
        chk("sm.frame_cnt", int'(s_fc), es.fc);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst.big.hpos", int'(b_h), 799);
        chk("rst.big.vpos", int'(b_v), 524);
        chk("rst.big.hsync", int'(b_hs), 1);
        chk("rst.big.vsync", int'(b_vs), 1);
        chk("rst.big.display_on", int'(b_de), 0);
        chk("rst.big.line_start", int'(b_ls), 0);
        chk("rst.big.frame_start", int'(b_fs), 0);
        chk("rst.sm.hpos", int'(s_h), 13);
        chk("rst.sm.vpos", int'(s_v), 6);
        chk("rst.sm.hsync", int'(s_hs), 0);
        chk("rst.sm.vsync", int'(s_vs), 1);
`ifdef VGA_FRAME_COUNTER_EN
        chk("rst.big.frame_cnt", int'(b_fc), 255);
`endif
    endtask

    task automatic chk_first_vals();
        chk("first.big.hpos", int'(b_h), 0);
        chk("first.big.vpos", int'(b_v), 0);
        chk("first.big.display_on", int'(b_de), 1);
        chk("first.big.line_start", int'(b_ls), 1);
        chk("first.big.frame_start", int'(b_fs), 1);
        chk("first.big.hsync", int'(b_hs), 1);
        chk("first.sm.hpos", int'(s_h), 0);
        chk("first.sm.frame_start", int'(s_fs), 1);
        chk("first.sm.hsync", int'(s_hs), 0);
`ifdef VGA_FRAME_COUNTER_EN
        chk("first.big.frame_cnt", int'(b_fc), 0);
`endif
    endtask

    initial begin
        int hs_hi, vs_lo, fs_cnt, fs_idx;
        rst_n = 1'b0;
        ena   = 1'b1;
        repeat (3) step();
        chk_reset_vals();

        rst_n = 1'b1;
        step();
        chk_first_vals();

        // One full line of the 640x480 raster from vpos 0.
        for (int k = 1; k < 800; k++) begin
            step();
            if (k == 639) chk("big.de@639", int'(b_de), 1);
            if (k == 640) chk("big.de@640", int'(b_de), 0);
            if (k == 655) chk("big.hs@655", int'(b_hs), 1);
            if (k == 656) chk("big.hs@656", int'(b_hs), 0);
            if (k == 751) chk("big.hs@751", int'(b_hs), 0);
            if (k == 752) chk("big.hs@752", int'(b_hs), 1);
        end
        chk("big.hpos@end_line", int'(b_h), 799);
        step();
        chk("wrap.big.hpos", int'(b_h), 0);
        chk("wrap.big.vpos", int'(b_v), 1);
        chk("wrap.big.line_start", int'(b_ls), 1);
        chk("wrap.big.frame_start", int'(b_fs), 0);

        // Enable hold on the last pixel of a line.
        repeat (1599) step();
        chk("pre_hold.big.hpos", int'(b_h), 799);
        chk("pre_hold.big.vpos", int'(b_v), 2);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold.big.hpos", int'(b_h), 799);
            chk("hold.big.vpos", int'(b_v), 2);
            chk("hold.big.line_start", int'(b_ls), 0);
        end
        ena = 1'b1;
        step();
        chk("resume.big.hpos", int'(b_h), 0);
        chk("resume.big.vpos", int'(b_v), 3);
        chk("resume.big.line_start", int'(b_ls), 1);
        step();
        chk("resume2.big.line_start", int'(b_ls), 0);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1 chk_reset_vals();
        step();
        rst_n = 1'b1;
        step();
        chk_first_vals();

        // One full small frame: hsync only at 10..11, vsync one line, frame period 98.
        hs_hi = 0; vs_lo = 0; fs_cnt = 0; fs_idx = -1;
        for (int k = 1; k <= 98; k++) begin
            step();
            if (s_hs) begin
                hs_hi++;
                chk("sm.hs_window", (s_h >= 10 && s_h <= 11) ? 1 : 0, 1);
            end
            if (!s_vs) vs_lo++;
            if (s_fs) begin
                fs_cnt++;
                fs_idx = k;
            end
        end
        chk("sm.hsync_high_clocks", hs_hi, 14);
        chk("sm.vsync_low_clocks", vs_lo, 14);
        chk("sm.frame_start_count", fs_cnt, 1);
        chk("sm.frame_period", fs_idx, 98);
`ifdef VGA_FRAME_COUNTER_EN
        chk("sm.frame_cnt@2nd", int'(s_fc), 1);
        repeat (98 * 254) step();
        chk("sm.frame_cnt@256th", int'(s_fc), 255);
        repeat (98) step();
        chk("sm.frame_cnt@wrap", int'(s_fc), 0);
`endif

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator sitting directly upstream of the pixel/pattern logic in the top-level VGA design.
- Produces registered hsync/vsync, display_on, and current pixel coordinates hpos/vpos; the pattern stage uses these to compute RGB for the same cycle.
- Also produces one-cycle line/frame strobes so downstream animation logic needs no edge detection.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync (0 = active-low)

Ports:
- clk  input  1  pixel clock (25.175 MHz nominal)
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  advance enable; counters/outputs hold when low
- hsync  output  1  horizontal sync, polarity per HSYNC_POL
- vsync  output  1  vertical sync, polarity per VSYNC_POL
- display_on  output  1  high when (hpos,vpos) is in the visible area
- hpos  output  10  current column, 0..H_TOTAL-1
- vpos  output  10  current row, 0..V_TOTAL-1
- line_start  output  1  one-cycle pulse when hpos becomes 0
- frame_start  output  1  one-cycle pulse when hpos and vpos both become 0

Behaviour:
- Derived constants: H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- Clocking: single clock clk; reset rst_n is asynchronous, active-low.
- Registered outputs: all outputs are flops, with no combinational path from inputs to outputs.
  - hsync, vsync and display_on are decoded from next-state counter values.
  - They therefore always describe the hpos/vpos presented in the same cycle (zero relative latency).
- Reset values:
  - hpos = H_TOTAL-1 and vpos = V_TOTAL-1.
  - hsync = ~HSYNC_POL and vsync = ~VSYNC_POL (both inactive).
  - display_on = 0, line_start = 0, frame_start = 0.
- First enabled clock after reset: hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1.
- Advancing cycle (ena=1):
  - hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos wraps from V_TOTAL-1 to 0 when hpos wraps.
- hsync active iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751).
- vsync active iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491). vsync is line-aligned and changes with hpos=0.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
- Strobes:
  - line_start = 1 only in the cycle following an advancing clock that produced hpos==0.
  - frame_start = the same condition with vpos==0 as well.
- Hold cycle (ena=0):
  - hpos, vpos, hsync, vsync and display_on hold their values.
  - line_start and frame_start are forced to 0, so a held cycle never repeats a pulse.
- Reset mid-frame: immediate return to reset values regardless of clk. Resumption behaves exactly as after power-up reset.
- Widths: 10-bit counters. Parameters must satisfy H_TOTAL <= 1024 and V_TOTAL <= 1024; no other range checking is performed.

Optional Feature:
- Macro VGA_FRAME_COUNTER_EN.
- Defined:
  - Adds output frame_cnt (8 bits).
  - Reset value 255; increments on every advancing clock that produces frame_start, wrapping 255->0. The first frame after reset therefore reads 0.
  - Holds when ena=0.
- Undefined: the port and the logic are absent.

Test Plan:
- Reset: assert rst_n=0 mid-run with no clock edge.
  - Required: hpos=799, vpos=524, hsync=1, vsync=1, display_on=0, both strobes 0.
  - After release and one clk with ena=1: hpos=0, vpos=0, display_on=1, line_start=1, frame_start=1.
- Horizontal timing: run one line from vpos=0.
  - hsync goes low at hpos=656 and high again at hpos=752.
  - display_on falls at hpos=640.
  - 799->0 wrap increments vpos to 1, with line_start=1 and frame_start=0.
- Vertical timing: run a full frame.
  - vsync is low exactly for vpos 490..491, i.e. 1600 clocks.
  - display_on is 0 for all vpos >= 480.
  - frame_start recurs every 420000 clocks.
- Enable hold: drop ena for 5 cycles at hpos=799, vpos=100.
  - Outputs frozen and strobes 0 throughout.
  - Next enabled clock gives hpos=0, vpos=101, line_start=1 for exactly one cycle.
- Frame counter (VGA_FRAME_COUNTER_EN defined):
  - frame_cnt=0 after the first frame_start and 1 after the second.
  - Forced wrap from 255 goes to 0.
  - Build without the macro compiles with no frame_cnt port.
- Small-parameter build (H 8/2/2/2, V 4/1/1/1, HSYNC_POL=1):
  - hsync high only for hpos 10..11.
  - Full frame is 14x7 = 98 clocks.
